// File: rtl/sr_latch_exerciser.sv
// Built-in self-test engine for a gated SR latch: sweeps every {en,s,r} drive,
// compares q/qbar against a reference model and reports mismatches.
module sr_latch_exerciser #(
   parameter int SETTLE        = 2,
   parameter int PASSES        = 2,
   parameter int CNT_W         = 8,
   parameter int ALLOW_ILLEGAL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             en,
   output logic             s,
   output logic             r,
   input  logic             q,
   input  logic             qbar,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_cnt,
   output logic             fail,
   output logic [2:0]       last_vec
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_APPLY = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int WAIT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
   localparam int PASS_W = (PASSES < 2) ? 1 : $clog2(PASSES);

   localparam logic [2:0]        VEC_INIT  = 3'b101;
   localparam logic [2:0]        VEC_LAST  = (ALLOW_ILLEGAL != 0) ? 3'd7 : 3'd6;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   state_t            state_r;
   logic [2:0]        vec_r;
   logic              init_r;
   logic [PASS_W-1:0] pass_r;
   logic [WAIT_W-1:0] wait_r;
   logic              model_r;
   logic              known_r;

   logic [2:0]        vec_next_s;
   logic              vec_wrap_s;
   logic              mismatch_s;

   // Reference latch step: returns {known, value} after applying drive v.
   function automatic logic [1:0] model_step(input logic [2:0] v,
                                             input logic       known,
                                             input logic       value);
      logic [1:0] res;
      case (v)
         3'b110:  res = {1'b1, 1'b1};
         3'b101:  res = {1'b1, 1'b0};
         3'b111:  res = {1'b0, value};
         default: res = {known, value};
      endcase
      return res;
   endfunction

   // Next-vector selection and mismatch detection for the CHECK state.
   always_comb begin
      vec_next_s = 3'd0;
      vec_wrap_s = 1'b0;
      mismatch_s = known_r & ((q != model_r) | (qbar == model_r));
      if (init_r) begin
         vec_next_s = 3'd0;
         vec_wrap_s = 1'b0;
      end else if (vec_r == VEC_LAST) begin
         vec_next_s = 3'd0;
         vec_wrap_s = 1'b1;
      end else begin
         vec_next_s = vec_r + 3'd1;
         vec_wrap_s = 1'b0;
      end
   end

   // Run sequencer: all drives and status outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         vec_r    <= 3'd0;
         init_r   <= 1'b0;
         pass_r   <= {PASS_W{1'b0}};
         wait_r   <= {WAIT_W{1'b0}};
         model_r  <= 1'b0;
         known_r  <= 1'b1;
         en       <= 1'b0;
         s        <= 1'b0;
         r        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err_cnt  <= {CNT_W{1'b0}};
         fail     <= 1'b0;
         last_vec <= 3'd0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_r  <= ST_APPLY;
                  vec_r    <= VEC_INIT;
                  init_r   <= 1'b1;
                  pass_r   <= {PASS_W{1'b0}};
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err_cnt  <= {CNT_W{1'b0}};
                  fail     <= 1'b0;
                  last_vec <= 3'd0;
               end
            end
            ST_APPLY: begin
               {en, s, r}         <= vec_r;
               {known_r, model_r} <= model_step(vec_r, known_r, model_r);
               wait_r             <= {WAIT_W{1'b0}};
               state_r            <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_r == WAIT_LAST) begin
                  state_r <= ST_CHECK;
               end else begin
                  wait_r <= wait_r + WAIT_W'(1);
               end
            end
            ST_CHECK: begin
               if (mismatch_s) begin
                  if (err_cnt != CNT_MAX) begin
                     err_cnt <= err_cnt + CNT_W'(1);
                  end
                  fail     <= 1'b1;
                  last_vec <= vec_r;
               end
               vec_r  <= vec_next_s;
               init_r <= 1'b0;
               // A wrap on the final pass ends the run and parks the drives low.
               if (vec_wrap_s && (pass_r == PASS_LAST)) begin
                  state_r    <= ST_DONE;
                  pass_r     <= {PASS_W{1'b0}};
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  {en, s, r} <= 3'b000;
               end else if (vec_wrap_s) begin
                  pass_r  <= pass_r + PASS_W'(1);
                  state_r <= ST_APPLY;
               end else begin
                  state_r <= ST_APPLY;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               busy       <= 1'b0;
               done       <= 1'b0;
               {en, s, r} <= 3'b000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_latch_exerciser.sv
// Directed bench for sr_latch_exerciser: three instances (defaults, CNT_W=2,
// ALLOW_ILLEGAL=1) each beside a behavioural gated SR latch with a stuck-at-0 option.
module tb_sr_latch_exerciser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start;
   logic [2:0] en_w, s_w, r_w, q_w, qbar_w, busy_w, done_w, fail_w;
   logic [2:0] stuck = 3'b000;
   logic [2:0] st = 3'b000;
   logic [7:0] err0, err2;
   logic [1:0] err1;
   logic [2:0] lv0, lv1, lv2;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int n0 = 0;
   int d0, d1, d2;
   bit saw7_0, saw7_2, wrap1;
   logic [1:0] prev1;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Behavioural latch per instance; updated mid-cycle so q/qbar are settled well before CHECK.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (en_w[k] & s_w[k] & ~r_w[k])      st[k] <= 1'b1;
         else if (en_w[k] & ~s_w[k] & r_w[k]) st[k] <= 1'b0;
      end
   end
   assign q_w    = st & ~stuck & ~(en_w & s_w & r_w);
   assign qbar_w = ~st & ~(en_w & s_w & r_w);

   sr_latch_exerciser u0 (
      .clk(clk), .rst(rst), .start(start), .en(en_w[0]), .s(s_w[0]), .r(r_w[0]),
      .q(q_w[0]), .qbar(qbar_w[0]), .busy(busy_w[0]), .done(done_w[0]),
      .err_cnt(err0), .fail(fail_w[0]), .last_vec(lv0));

   sr_latch_exerciser #(.CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .start(start), .en(en_w[1]), .s(s_w[1]), .r(r_w[1]),
      .q(q_w[1]), .qbar(qbar_w[1]), .busy(busy_w[1]), .done(done_w[1]),
      .err_cnt(err1), .fail(fail_w[1]), .last_vec(lv1));

   sr_latch_exerciser #(.ALLOW_ILLEGAL(1)) u2 (
      .clk(clk), .rst(rst), .start(start), .en(en_w[2]), .s(s_w[2]), .r(r_w[2]),
      .q(q_w[2]), .qbar(qbar_w[2]), .busy(busy_w[2]), .done(done_w[2]),
      .err_cnt(err2), .fail(fail_w[2]), .last_vec(lv2));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start pulse driven just after edge 0 (sampled at edge 1); returns at the negedge after edge 1.
   task automatic do_start();
      @(posedge clk);
      #1;
      n0 = edge_cnt;
      start = 1'b1;
      @(negedge clk);
      check_eq("busy_before_e1", {31'd0, busy_w[0]}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("busy_after_e1", {31'd0, busy_w[0]}, 32'd1);
   endtask

   // Watches a run for max_cyc cycles, optionally injecting rst and extra start pulses.
   task automatic run_wait(input int max_cyc, input int rst_at, input int re_a, input int re_b);
      int rel;
      d0 = -1; d1 = -1; d2 = -1;
      saw7_0 = 1'b0; saw7_2 = 1'b0; wrap1 = 1'b0;
      prev1 = err1;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         rel = edge_cnt - n0;
         if (done_w[0] && d0 < 0) d0 = rel;
         if (done_w[1] && d1 < 0) d1 = rel;
         if (done_w[2] && d2 < 0) d2 = rel;
         if ({en_w[0], s_w[0], r_w[0]} == 3'b111) saw7_0 = 1'b1;
         if ({en_w[2], s_w[2], r_w[2]} == 3'b111) saw7_2 = 1'b1;
         if (err1 < prev1) wrap1 = 1'b1;
         prev1 = err1;
         if (rst_at >= 0 && rel == rst_at) begin
            check_eq("busy_before_rst", {31'd0, busy_w[0]}, 32'd1);
         end
         if (rst_at >= 0 && rel == rst_at + 1) begin
            check_eq("rst_busy", {31'd0, busy_w[0]}, 32'd0);
            check_eq("rst_done", {31'd0, done_w[0]}, 32'd0);
            check_eq("rst_drives", {29'd0, en_w[0], s_w[0], r_w[0]}, 32'd0);
         end
         start = (rel == re_a) || (rel == re_b);
         rst   = (rel == rst_at);
      end
      start = 1'b0;
      rst   = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check_eq("rst_vs_start_busy", {31'd0, busy_w[0]}, 32'd0);
      check_eq("reset_done", {29'd0, done_w}, 32'd0);
      check_eq("reset_drives", {23'd0, en_w, s_w, r_w}, 32'd0);
      check_eq("reset_err0", {24'd0, err0}, 32'd0);
      check_eq("reset_fail", {29'd0, fail_w}, 32'd0);
      check_eq("reset_last_vec", {29'd0, lv0}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Good latches on every instance.
      stuck = 3'b000;
      do_start();
      run_wait(80, -1, -1, -1);
      check_eq("good_done_edge", d0, 32'd61);
      check_eq("good_err", {24'd0, err0}, 32'd0);
      check_eq("good_fail", {31'd0, fail_w[0]}, 32'd0);
      check_eq("good_no_illegal", {31'd0, saw7_0}, 32'd0);
      check_eq("done_drives", {29'd0, en_w[0], s_w[0], r_w[0]}, 32'd0);
      check_eq("done_busy", {31'd0, busy_w[0]}, 32'd0);
      check_eq("ill_done_edge", d2, 32'd69);
      check_eq("ill_seen_111", {31'd0, saw7_2}, 32'd1);
      check_eq("ill_err", {24'd0, err2}, 32'd0);
      check_eq("ill_fail", {31'd0, fail_w[2]}, 32'd0);

      // q stuck-at-0 on the default and narrow-counter instances.
      stuck = 3'b011;
      do_start();
      run_wait(70, -1, -1, -1);
      check_eq("stuck_done_edge", d0, 32'd61);
      check_eq("stuck_err", {24'd0, err0}, 32'd7);
      check_eq("stuck_fail", {31'd0, fail_w[0]}, 32'd1);
      check_eq("stuck_last_vec", {29'd0, lv0}, 32'd6);
      check_eq("sat_done_edge", d1, 32'd61);
      check_eq("sat_err", {30'd0, err1}, 32'd3);
      check_eq("sat_no_wrap", {31'd0, wrap1}, 32'd0);
      check_eq("sat_fail", {31'd0, fail_w[1]}, 32'd1);

      // Restart clears the status; reset mid-run abandons the run.
      stuck = 3'b000;
      do_start();
      check_eq("restart_err_clr", {24'd0, err0}, 32'd0);
      check_eq("restart_fail_clr", {31'd0, fail_w[0]}, 32'd0);
      check_eq("restart_lv_clr", {29'd0, lv0}, 32'd0);
      check_eq("restart_done_clr", {31'd0, done_w[0]}, 32'd0);
      run_wait(90, 20, -1, -1);
      check_eq("abandoned_no_done", d0, 32'hffff_ffff);

      // Clean rerun with start pulses while busy.
      do_start();
      run_wait(70, -1, 10, 30);
      check_eq("busy_start_done_edge", d0, 32'd61);
      check_eq("busy_start_err", {24'd0, err0}, 32'd0);
      check_eq("busy_start_fail", {31'd0, fail_w[0]}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
